shared_pipe_array: RTL and testbench

- N-channel generalisation of the dual-pipeline block with shared resource and global stall.
- N_CH independent in-order pipelines, each DEPTH register stages deep.
- At stage SHARED_STAGE every item must pass through a single shared execution unit, arbitrated round-robin.
- Sits between the producer FSM and consumer FSM. Per-channel stall is the backpressure to the producer; per-channel flush comes from the producer.

---
 rtl/shared_pipe_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/shared_pipe_array.sv | 86 ++++++++
 tb/tb_shared_pipe_array.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pipe_pkg.sv
// Shared definitions for the multi-channel pipeline array: reset values,
// index-width helper and the round-robin pick function used by the arbiter.
package shared_pipe_pkg;

  // Widest channel count the pick function can scan.
  localparam int MAX_CH = 32;

  // Reset value of the round-robin pointer.
  localparam int PTR_RST = 0;

  // Width needed to hold a channel index (at least one bit).
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the first requester found scanning ptr, ptr+1, ... mod n;
  // -1 when nobody requests.
  function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int ptr, input int n);
    int pick;
    int idx;
    pick = -1;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && (pick < 0) && (idx < MAX_CH)) begin
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the shared execution unit. Grant is one-hot and
// combinational; the pointer moves just past the winner on every grant.
module rr_arbiter
  import shared_pipe_pkg::*;
#(
  parameter int N_CH = 2,
  localparam int CH_IDX_W = ch_idx_w(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant
);

  logic [CH_IDX_W-1:0] ptr;
  logic [MAX_CH-1:0]   req_ext;
  int                  win;

  // Pick the winner starting from the pointer position.
  always_comb begin
    req_ext = '0;
    req_ext[N_CH-1:0] = req;
    win = rr_pick(req_ext, int'(ptr), N_CH);
  end

  // Expand the winner index into a one-hot grant vector.
  always_comb begin
    grant = '0;
    for (int c = 0; c < N_CH; c++) begin
      grant[c] = (win == c);
    end
  end

  // Advance the pointer past the winner; hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= CH_IDX_W'(PTR_RST);
    end else if (win >= 0) begin
      ptr <= (win == N_CH - 1) ? CH_IDX_W'(PTR_RST) : CH_IDX_W'(win + 1);
    end
  end

endmodule

// File: rtl/shared_pipe_array.sv
// N_CH in-order pipelines sharing one incrementing execution unit at stage
// SHARED_STAGE. A channel that requests the unit and loses arbitration
// freezes every one of its stages (global stall) and refuses new input.
// Handshake: in_valid/in_data are taken at the clock edge only when stall
// and flush are both low for that channel; while stall is high the
// producer holds them. out_valid strobes once per item, never while the
// final stage is frozen.
module shared_pipe_array
  import shared_pipe_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 3,
  parameter int SHARED_STAGE = 1,
  parameter int INC          = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       flush,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  output logic [N_CH-1:0]       stall,
  output logic [N_CH*CNT_W-1:0] stall_cnt
);

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [CNT_W-1:0] cnt;

    // Reset gating keeps stall/out_valid quiet during the reset cycle.
    assign req[c]       = vld[SHARED_STAGE] & ~flush[c] & ~reset;
    assign stall[c]     = req[c] & ~grant[c];
    assign out_valid[c] = vld[DEPTH-1] & ~stall[c] & ~flush[c] & ~reset;
    assign out_data[c*WIDTH +: WIDTH] = dat[DEPTH-1];
    assign stall_cnt[c*CNT_W +: CNT_W] = cnt;

    // Stage registers: flush kills, stall freezes, otherwise shift forward
    // with the shared unit adding INC on the way out of SHARED_STAGE.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          dat[k] <= '0;
        end
      end else if (flush[c]) begin
        vld <= '0;
      end else if (!stall[c]) begin
        vld    <= {vld[DEPTH-2:0], in_valid[c]};
        dat[0] <= in_data[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) begin
          if ((k == SHARED_STAGE + 1) && vld[SHARED_STAGE]) begin
            dat[k] <= dat[k-1] + WIDTH'(INC);
          end else begin
            dat[k] <= dat[k-1];
          end
        end
      end
    end

    // Saturating count of stalled cycles; only reset clears it.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (stall[c] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_pipe_array.sv
// Bench for shared_pipe_array: two instances (2 channels default; 4
// channels with narrow data/counters and a deeper pipe) driven by directed
// and random stimulus and checked every cycle against a queue-based model.
module tb_shared_pipe_array;

  localparam int CFG_N   [2] = '{2, 4};
  localparam int CFG_W   [2] = '{32, 8};
  localparam int CFG_D   [2] = '{3, 4};
  localparam int CFG_SS  [2] = '{1, 2};
  localparam int CFG_INC [2] = '{1, 3};
  localparam int CFG_CW  [2] = '{16, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_in_valid, a_flush, a_out_valid, a_stall;
  logic [31:0] a_stall_cnt;
  logic [31:0] b_in_data, b_out_data;
  logic [3:0]  b_in_valid, b_flush, b_out_valid, b_stall;
  logic [7:0]  b_stall_cnt;

  logic [31:0] i_data  [2][4];
  logic        i_valid [2][4];
  logic        i_flush [2][4];
  logic [31:0] o_data  [2][4];
  logic        o_valid [2][4];
  logic        o_stall [2][4];
  logic [15:0] o_cnt   [2][4];

  shared_pipe_array dut_a (
    .clk (clk), .reset (reset),
    .in_data (a_in_data), .in_valid (a_in_valid), .flush (a_flush),
    .out_data (a_out_data), .out_valid (a_out_valid), .stall (a_stall),
    .stall_cnt (a_stall_cnt)
  );

  shared_pipe_array #(
    .N_CH (4), .WIDTH (8), .DEPTH (4), .SHARED_STAGE (2), .INC (3), .CNT_W (2)
  ) dut_b (
    .clk (clk), .reset (reset),
    .in_data (b_in_data), .in_valid (b_in_valid), .flush (b_flush),
    .out_data (b_out_data), .out_valid (b_out_valid), .stall (b_stall),
    .stall_cnt (b_stall_cnt)
  );

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      a_in_data[c*32 +: 32] = i_data[0][c];
      a_in_valid[c] = i_valid[0][c];
      a_flush[c]    = i_flush[0][c];
    end
    for (int c = 0; c < 4; c++) begin
      b_in_data[c*8 +: 8] = i_data[1][c][7:0];
      b_in_valid[c] = i_valid[1][c];
      b_flush[c]    = i_flush[1][c];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        o_data[i][c] = '0; o_valid[i][c] = 1'b0; o_stall[i][c] = 1'b0; o_cnt[i][c] = '0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      o_data[0][c]  = a_out_data[c*32 +: 32];
      o_valid[0][c] = a_out_valid[c];
      o_stall[0][c] = a_stall[c];
      o_cnt[0][c]   = a_stall_cnt[c*16 +: 16];
    end
    for (int c = 0; c < 4; c++) begin
      o_data[1][c]  = {24'd0, b_out_data[c*8 +: 8]};
      o_valid[1][c] = b_out_valid[c];
      o_stall[1][c] = b_stall[c];
      o_cnt[1][c]   = {14'd0, b_stall_cnt[c*2 +: 2]};
    end
  end

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  // Per channel: items in flight, oldest first, with their stage position.
  logic [31:0] exp_q [2][4][$];
  int          pos_q [2][4][$];
  int          ptr_m [2];
  int          cnt_m [2][4];
  int          win_m [2];
  logic        e_stall [2][4];
  bit          inited = 0;
  bit          just_reset = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int i);
    return (CFG_W[i] == 32) ? 32'hffff_ffff : ((32'd1 << CFG_W[i]) - 32'd1);
  endfunction

  // Predict this cycle's outputs from the model and compare.
  task automatic eval_inst(input int i);
    int   n, idx, win;
    logic req [4];
    logic fin, exp_ov;
    n = CFG_N[i];
    for (int c = 0; c < 4; c++) req[c] = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!reset && !i_flush[i][c]) begin
        for (int k = 0; k < pos_q[i][c].size(); k++) begin
          if (pos_q[i][c][k] == CFG_SS[i]) req[c] = 1'b1;
        end
      end
    end
    win = -1;
    for (int k = 0; k < n; k++) begin
      idx = (ptr_m[i] + k) % n;
      if (win < 0 && req[idx]) win = idx;
    end
    win_m[i] = win;
    for (int c = 0; c < n; c++) begin
      e_stall[i][c] = req[c] && (c != win);
      fin = (pos_q[i][c].size() > 0) && (pos_q[i][c][0] == CFG_D[i] - 1);
      exp_ov = fin && !e_stall[i][c] && !i_flush[i][c] && !reset;
      if (inited) begin
        check($sformatf("i%0d_c%0d_out_valid", i, c), 32'(o_valid[i][c]), 32'(exp_ov));
        check($sformatf("i%0d_c%0d_stall", i, c), 32'(o_stall[i][c]), 32'(e_stall[i][c]));
        check($sformatf("i%0d_c%0d_stall_cnt", i, c), 32'(o_cnt[i][c]), 32'(cnt_m[i][c]));
        if (fin && !i_flush[i][c] && !reset)
          check($sformatf("i%0d_c%0d_out_data", i, c), o_data[i][c],
                (exp_q[i][c][0] + 32'(CFG_INC[i])) & mask_of(i));
        if (just_reset && !reset)
          check($sformatf("i%0d_c%0d_rst_data", i, c), o_data[i][c], 32'd0);
      end
    end
  endtask

  // Apply the clock edge to the model.
  task automatic commit_inst(input int i);
    int n;
    n = CFG_N[i];
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        exp_q[i][c].delete(); pos_q[i][c].delete(); cnt_m[i][c] = 0;
      end
      ptr_m[i] = 0;
      return;
    end
    for (int c = 0; c < n; c++) begin
      if (e_stall[i][c] && cnt_m[i][c] < (1 << CFG_CW[i]) - 1) cnt_m[i][c]++;
      if (i_flush[i][c]) begin
        exp_q[i][c].delete(); pos_q[i][c].delete();
      end else if (!e_stall[i][c]) begin
        if (pos_q[i][c].size() > 0 && pos_q[i][c][0] == CFG_D[i] - 1) begin
          void'(exp_q[i][c].pop_front()); void'(pos_q[i][c].pop_front());
        end
        for (int k = 0; k < pos_q[i][c].size(); k++) pos_q[i][c][k] = pos_q[i][c][k] + 1;
        if (i_valid[i][c]) begin
          exp_q[i][c].push_back(i_data[i][c] & mask_of(i));
          pos_q[i][c].push_back(0);
        end
      end
    end
    if (win_m[i] >= 0) ptr_m[i] = (win_m[i] + 1) % n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycle();
    @(negedge clk);
    eval_inst(0); eval_inst(1);
    @(posedge clk);
    commit_inst(0); commit_inst(1);
    if (reset) inited = 1;
    just_reset = reset;
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) begin
        i_valid[i][c] = 1'b0; i_flush[i][c] = 1'b0; i_data[i][c] = '0;
      end
  endtask

  task automatic put(input int i, input int c, input logic [31:0] d);
    i_valid[i][c] = 1'b1; i_data[i][c] = d;
  endtask

  task automatic idle_cycles(input int n);
    idle_all();
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  // Random producer: holds its inputs while the channel was stalled.
  task automatic drive_random(input int i, input int vpct, input int fpct);
    for (int c = 0; c < CFG_N[i]; c++) begin
      i_flush[i][c] = ($urandom_range(0, 99) < fpct);
      if (!e_stall[i][c]) begin
        i_valid[i][c] = ($urandom_range(0, 99) < vpct);
        i_data[i][c]  = $urandom;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      ptr_m[i] = 0; win_m[i] = -1;
      for (int c = 0; c < 4; c++) begin cnt_m[i][c] = 0; e_stall[i][c] = 1'b0; end
    end
    idle_all();
    reset = 1'b1;
    run_cycle(); run_cycle();
    reset = 1'b0;

    // Single item on channel 0.
    put(0, 0, 32'd5); run_cycle(); idle_cycles(5);

    // Simultaneous items on both channels contend for the shared unit.
    put(0, 0, 32'd10); put(0, 1, 32'd20); run_cycle(); idle_cycles(6);

    // Back-to-back traffic on both channels, producer honours stall.
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 2; c++)
        if (!e_stall[0][c]) put(0, c, 32'(100 + 2 * k + c));
      run_cycle();
    end
    idle_cycles(8);

    // Channel 1 flushed while its item waits at the shared stage.
    put(0, 0, 32'd30); put(0, 1, 32'd40); run_cycle();
    idle_cycles(1);
    i_flush[0][1] = 1'b1; run_cycle();
    idle_cycles(5);

    // Reset with items in flight, then one fresh item.
    for (int k = 0; k < 3; k++) begin
      put(0, 0, 32'(50 + k)); put(0, 1, 32'(60 + k)); run_cycle();
    end
    idle_all(); reset = 1'b1; run_cycle(); reset = 1'b0;
    idle_cycles(2);
    put(0, 0, 32'd77); run_cycle(); idle_cycles(6);

    // Four-channel instance: move pointer to 2, then 0, 2, 3 contend.
    put(1, 1, 32'd9); run_cycle(); idle_cycles(4);
    put(1, 0, 32'd1); put(1, 2, 32'd2); put(1, 3, 32'd3); run_cycle();
    idle_cycles(10);

    // Random traffic on both instances with occasional flush and reset.
    for (int k = 0; k < 3000; k++) begin
      drive_random(0, 70, 5);
      drive_random(1, 80, 4);
      reset = (k < 2500) && ($urandom_range(0, 499) == 0);
      run_cycle();
    end
    reset = 1'b0;
    idle_cycles(10);

    // Narrow counters must have saturated under sustained contention.
    @(negedge clk);
    for (int c = 0; c < 4; c++)
      check($sformatf("i1_c%0d_sat", c), 32'(o_cnt[1][c]), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
